// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative multiply / divide unit for the execute stage.
// One bit is processed per clock. Multiply is shift-add and divide is restoring.
//   multiply: result = low product, result2 = high product
//   divide  : result = quotient,    result2 = remainder
// Optional feature macro: MULDIV_SIGNED_EN. It adds two's-complement operation
// through magnitude capture and a one-cycle FIX state that negates results.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             op,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result2,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
`ifdef MULDIV_SIGNED_EN
    FIX  = 2'd3,
`endif
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             op_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] acc_r;     // product high half / partial remainder
  logic [WIDTH-1:0] q_r;       // product low half / quotient

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_sh_s;
  logic [WIDTH+1:0] div_trial_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0] q_nxt_s;
  logic [WIDTH-1:0] x_mag_s;
  logic [WIDTH-1:0] y_mag_s;
  logic             unused_s;

`ifdef MULDIV_SIGNED_EN
  logic               signed_r;
  logic               neg_a_r;   // negate product or quotient
  logic               neg_b_r;   // negate remainder (sign of dividend)
  logic               x_neg_s;
  logic               y_neg_s;
  logic [2*WIDTH-1:0] fix_prod_s;

  // Operand sign detection, magnitudes and the negated product used in FIX
  always_comb begin
    x_neg_s    = op_signed & x[WIDTH-1];
    y_neg_s    = op_signed & y[WIDTH-1];
    x_mag_s    = x_neg_s ? ({WIDTH{1'b0}} - x) : x;
    y_mag_s    = y_neg_s ? ({WIDTH{1'b0}} - y) : y;
    fix_prod_s = {(2*WIDTH){1'b0}} - {result2, result};
  end

  assign unused_s = div_trial_s[WIDTH];
`else
  // Unsigned build: operands pass straight through
  always_comb begin
    x_mag_s = x;
    y_mag_s = y;
  end

  assign unused_s = ^{div_trial_s[WIDTH], op_signed};
`endif

  // One shift-add or restoring-divide step from the current working registers
  always_comb begin
    mul_sum_s   = {1'b0, acc_r};
    if (q_r[0]) begin
      mul_sum_s = {1'b0, acc_r} + {1'b0, y_r};
    end else begin
      mul_sum_s = {1'b0, acc_r};
    end
    div_sh_s    = {acc_r, q_r[WIDTH-1]};
    div_trial_s = {1'b0, div_sh_s} - {2'b00, y_r};
    if (op_r) begin
      if (div_trial_s[WIDTH+1]) begin
        acc_nxt_s = div_sh_s[WIDTH-1:0];
        q_nxt_s   = {q_r[WIDTH-2:0], 1'b0};
      end else begin
        acc_nxt_s = div_trial_s[WIDTH-1:0];
        q_nxt_s   = {q_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_nxt_s = mul_sum_s[WIDTH:1];
      q_nxt_s   = {mul_sum_s[0], q_r[WIDTH-1:1]};
    end
  end

  // Control FSM, iteration registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      op_r        <= 1'b0;
      y_r         <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      result      <= {WIDTH{1'b0}};
      result2     <= {WIDTH{1'b0}};
      res_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      start_ready <= 1'b1;
`ifdef MULDIV_SIGNED_EN
      signed_r    <= 1'b0;
      neg_a_r     <= 1'b0;
      neg_b_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start_valid) begin
            op_r        <= op;
            y_r         <= y_mag_s;
            q_r         <= x_mag_s;
            acc_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            busy        <= 1'b1;
            start_ready <= 1'b0;
            state_r     <= RUN;
`ifdef MULDIV_SIGNED_EN
            signed_r    <= op_signed;
            neg_a_r     <= x_neg_s ^ y_neg_s;
            neg_b_r     <= x_neg_s;
`endif
            // Divide by zero: preload the result; RUN completes it next edge
            if (op && (y == {WIDTH{1'b0}})) begin
              result      <= {WIDTH{1'b1}};
              result2     <= x;
              div_by_zero <= 1'b1;
            end else begin
              div_by_zero <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (div_by_zero) begin
            state_r   <= DONE;
            res_valid <= 1'b1;
          end else begin
            acc_r <= acc_nxt_s;
            q_r   <= q_nxt_s;
            if (cnt_r == CNT_LAST) begin
              result  <= q_nxt_s;
              result2 <= acc_nxt_s;
`ifdef MULDIV_SIGNED_EN
              if (signed_r) begin
                state_r <= FIX;
              end else begin
                state_r   <= DONE;
                res_valid <= 1'b1;
              end
`else
              state_r   <= DONE;
              res_valid <= 1'b1;
`endif
            end else begin
              state_r <= RUN;
            end
          end
        end
`ifdef MULDIV_SIGNED_EN
        FIX: begin
          if (!op_r) begin
            if (neg_a_r) begin
              {result2, result} <= fix_prod_s;
            end else begin
              {result2, result} <= {result2, result};
            end
          end else begin
            if (neg_a_r) begin
              result <= fix_prod_s[WIDTH-1:0];
            end else begin
              result <= result;
            end
            if (neg_b_r) begin
              result2 <= {WIDTH{1'b0}} - result2;
            end else begin
              result2 <= result2;
            end
          end
          state_r   <= DONE;
          res_valid <= 1'b1;
        end
`endif
        DONE: begin
          if (res_ready) begin
            state_r     <= IDLE;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          res_valid   <= 1'b0;
          busy        <= 1'b0;
          start_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed testbench for alu_muldiv_seq with an expected-result queue.
// Build with MULDIV_SIGNED_EN defined to also exercise the signed steps.
module tb_alu_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic         op = 1'b0;
  logic         op_signed = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result2;
  logic         div_by_zero;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;
  logic [2*W:0] sb_q[$];   // {div_by_zero, result2, result}

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .op_signed(op_signed), .x(x), .y(y),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .result2(result2),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation, check latency, result, backpressure and handshake
  task automatic run_op(input string tag, input logic o, input logic s,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic [W-1:0] er2,
                        input logic edbz, input int elat, input int hold);
    logic [2*W:0] e;
    int lat;
    @(negedge clk);
    check({tag, " start_ready"}, start_ready, 1);
    start_valid = 1'b1; op = o; op_signed = s; x = a; y = b;
    res_ready = (hold == 0);
    sb_q.push_back({edbz, er2, er});
    @(posedge clk); #1;
    start_valid = 1'b0; x = $urandom; y = $urandom; op = ~o; op_signed = ~s;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!res_valid && lat < 100);
    check({tag, " latency"}, lat, elat);
    e = sb_q.pop_front();
    check({tag, " result"}, result, e[W-1:0]);
    check({tag, " result2"}, result2, e[2*W-1:W]);
    check({tag, " div_by_zero"}, div_by_zero, e[2*W]);
    check({tag, " busy"}, busy, 1);
    for (int i = 0; i < hold; i++) begin
      start_valid = (i == 2);
      x = 32'h0000_0009; y = 32'h0000_0004; op = 1'b0;
      @(negedge clk);
      check({tag, " hold valid"}, res_valid, 1);
      check({tag, " hold result"}, {result2, result}, e[2*W-1:0]);
      check({tag, " hold start_ready"}, start_ready, 0);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check({tag, " post valid"}, res_valid, 0);
    check({tag, " post start_ready"}, start_ready, 1);
    check({tag, " post busy"}, busy, 0);
    res_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [63:0]  p;
    #12;
    check("reset result", result, 0);
    check("reset result2", result2, 0);
    check("reset res_valid", res_valid, 0);
    check("reset div_by_zero", div_by_zero, 0);
    check("reset busy", busy, 0);
    check("reset start_ready", start_ready, 1);
    @(negedge clk); rst = 1'b0;

    run_op("mul max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 32, 0);
    run_op("div 100/7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 0);
    run_op("div 5/9", 1'b1, 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 32, 0);
    run_op("div by zero", 1'b1, 1'b0, 32'h0000_1234, 32'd0,
           32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1, 0);
    run_op("mul backpressure", 1'b0, 1'b0, 32'd3, 32'd5, 32'd15, 32'd0, 1'b0, 32, 10);

    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      p = 64'(a) * 64'(b);
      run_op("mul random", 1'b0, 1'b0, a, b, p[31:0], p[63:32], 1'b0, 32, i);
      b = 32'($urandom_range(1, 70000));
      run_op("div random", 1'b1, 1'b0, a, b, a / b, a % b, 1'b0, 32, 0);
    end

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    start_valid = 1'b1; op = 1'b0; op_signed = 1'b0; x = 32'd3; y = 32'd5;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun rst res_valid", res_valid, 0);
    check("midrun rst busy", busy, 0);
    check("midrun rst start_ready", start_ready, 1);
    @(negedge clk); rst = 1'b0;
    run_op("div after rst", 1'b1, 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 32, 0);

`ifdef MULDIV_SIGNED_EN
    run_op("sdiv -7/2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 0);
    run_op("smul -3*5", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5,
           32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 33, 0);
    run_op("sdiv minneg/-1", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 32'd0, 1'b0, 33, 0);
    run_op("sdiv by zero", 1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0,
           32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
